fg_dac_write_sequencer: RTL

FG_DAC_WRITE_SEQUENCER -- requirements
Module: fg_dac_write_sequencer

---
 rtl/fg_dac_write_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fg_dac_write_sequencer.sv
// Sequences parallel DAC writes (setup, WR-low strobe, hold) from a sample stream with a 1-deep pending buffer.
// Optional FG_DAC_OVERRUN_COUNTER_EN adds a saturating 8-bit count of dropped samples.
module fg_dac_write_sequencer #(
    parameter int BITWIDTH      = 8,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [BITWIDTH-1:0] sample_i,
    input  logic                sampleValid_i,
    input  logic                clearOverrun_i,
    output logic [BITWIDTH-1:0] dac_o,
    output logic                dac_wr_n_o,
    output logic                busy_o,
    output logic                pendingFull_o,
    output logic                overrun_o,
    output logic [7:0]          overrunCount_o
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    state_t              state;
    logic [3:0]          phase_cnt;
    logic [BITWIDTH-1:0] pending;
    logic                last_hold;
    logic                overrun_event;

    // A sample is lost whenever a new one arrives mid-transaction while the buffer is occupied,
    // including the last HOLD cycle where the fresh sample takes priority over the buffered one.
    always_comb begin
        last_hold     = (state == HOLD) && (phase_cnt == 4'd0);
        overrun_event = enable_i && sampleValid_i && pendingFull_o && (state != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            phase_cnt     <= 4'd0;
            dac_o         <= '0;
            dac_wr_n_o    <= 1'b1;
            busy_o        <= 1'b0;
            pendingFull_o <= 1'b0;
            pending       <= '0;
            overrun_o     <= 1'b0;
        end else begin
            if (overrun_event)
                overrun_o <= 1'b1;
            else if (clearOverrun_i)
                overrun_o <= 1'b0;

            // The buffer is emptied at the end of every transaction: either consumed or superseded.
            if (!enable_i || last_hold) begin
                pendingFull_o <= 1'b0;
            end else if (sampleValid_i && (state != IDLE)) begin
                pending       <= sample_i;
                pendingFull_o <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable_i && sampleValid_i) begin
                        dac_o     <= sample_i;
                        state     <= SETUP;
                        phase_cnt <= SETUP_LOAD;
                        busy_o    <= 1'b1;
                    end
                end
                SETUP: begin
                    if (phase_cnt == 4'd0) begin
                        state      <= STROBE;
                        phase_cnt  <= STROBE_LOAD;
                        dac_wr_n_o <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (phase_cnt == 4'd0) begin
                        state      <= HOLD;
                        phase_cnt  <= HOLD_LOAD;
                        dac_wr_n_o <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (phase_cnt != 4'd0) begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end else if (enable_i && sampleValid_i) begin
                        dac_o     <= sample_i;
                        state     <= SETUP;
                        phase_cnt <= SETUP_LOAD;
                    end else if (enable_i && pendingFull_o) begin
                        dac_o     <= pending;
                        state     <= SETUP;
                        phase_cnt <= SETUP_LOAD;
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    phase_cnt  <= 4'd0;
                    dac_wr_n_o <= 1'b1;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

`ifdef FG_DAC_OVERRUN_COUNTER_EN
    logic [7:0] overrun_count;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            overrun_count <= 8'd0;
        else if (overrun_event && (overrun_count != 8'hFF))
            overrun_count <= overrun_count + 8'd1;
    end

    assign overrunCount_o = overrun_count;
`else
    assign overrunCount_o = 8'd0;
`endif

endmodule
